// File: rtl/mct_pulse_generator.sv
// mct_pulse_generator: parametrised memory-cycle-time pulse generator.
// Generates one-hot time pulses T01..Tn split into phases, per-phase RT/WT/CT
// strobes, the GOJAM restart sequence, standby and monitor stop / single-MCT
// stepping, plus a free-running scaler.
// Optional build macro: MCT_COUNT_EN adds the 32-bit completed-MCT counter
// on MCTCNT; without it MCTCNT is tied to zero.
module mct_pulse_generator #(
    parameter int NT       = 12,
    parameter int NPH      = 4,
    parameter int RT_PH    = 1,
    parameter int WT_PH    = 2,
    parameter int CT_PH    = 3,
    parameter int SCALER_W = 16
) (
    input  logic                CLOCK,
    input  logic                SIM_RST,
    input  logic                STRT1,
    input  logic                STRT2,
    input  logic                ALGA,
    input  logic                SBY,
    input  logic                MSTP,
    input  logic                MSTRTP,
    output logic [NT-1:0]       T,
    output logic [2:0]          PH,
    output logic                RT,
    output logic                WT,
    output logic                CT,
    output logic                MCT_END,
    output logic                GOJAM,
    output logic                GOJAM_n,
    output logic                STOP,
    output logic                STOP_n,
    output logic [SCALER_W-1:0] FS,
    output logic [31:0]         MCTCNT
);

    typedef enum logic [2:0] {S_JAM, S_RUN, S_STOPPED, S_STEP, S_STBY} state_t;

    localparam logic [2:0] PH_LAST = 3'(NPH - 1);
    localparam logic [4:0] TP_LAST = 5'(NT - 1);
    localparam logic [2:0] RT_SEL  = 3'(RT_PH);
    localparam logic [2:0] WT_SEL  = 3'(WT_PH);
    localparam logic [2:0] CT_SEL  = 3'(CT_PH);

    // ph_reg/tp_reg hold the position currently shown on the outputs.
    state_t        state_reg, state_next;
    logic [2:0]    ph_reg, ph_next;
    logic [4:0]    tp_reg, tp_next;
    logic          fresh_reg;        // set only out of reset: first edge shows T01 ph0
    logic          mstrtp_q1_reg, mstrtp_q2_reg;
    logic          restart, step_edge, at_end, counting_next, mct_end_next;
    logic [NT-1:0] t_next;

    logic [NT-1:0]       t_reg;
    logic [2:0]          ph_out_reg;
    logic                rt_reg, wt_reg, ct_reg, mct_end_reg, gojam_reg, stop_reg;
    logic [SCALER_W-1:0] fs_reg;

    assign restart   = STRT1 | STRT2 | ALGA;
    assign step_edge = mstrtp_q1_reg & ~mstrtp_q2_reg;
    assign at_end    = (ph_reg == PH_LAST) && (tp_reg == TP_LAST);

    // Next state and next displayed position; restart beats standby beats monitor.
    always_comb begin
        state_next = state_reg;
        ph_next    = 3'd0;
        tp_next    = 5'd0;
        if (restart) begin
            state_next = S_JAM;
        end else if (SBY) begin
            state_next = S_STBY;
        end else begin
            case (state_reg)
                S_JAM, S_RUN, S_STEP: begin
                    if (fresh_reg) begin
                        ph_next = 3'd0;
                        tp_next = 5'd0;
                    end else if (at_end) begin
                        state_next = MSTP ? S_STOPPED : S_RUN;
                    end else if (ph_reg == PH_LAST) begin
                        tp_next = tp_reg + 5'd1;
                    end else begin
                        ph_next = ph_reg + 3'd1;
                        tp_next = tp_reg;
                    end
                end
                S_STOPPED: begin
                    if (step_edge)  state_next = S_STEP;
                    else if (!MSTP) state_next = S_RUN;
                end
                S_STBY:  state_next = S_JAM;
                default: state_next = S_JAM;
            endcase
        end
    end

    assign counting_next = (state_next == S_JAM) || (state_next == S_RUN) ||
                           (state_next == S_STEP);
    assign mct_end_next  = counting_next && (ph_next == PH_LAST) && (tp_next == TP_LAST);

    // One-hot time pulse decode of the next pulse counter value.
    genvar gi;
    generate
        for (gi = 0; gi < NT; gi++) begin : g_tdec
            assign t_next[gi] = counting_next && (tp_next == 5'(gi));
        end
    endgenerate

    // State, counters, monitor-step edge detector and scaler.
    always_ff @(posedge CLOCK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            state_reg     <= S_JAM;
            ph_reg        <= 3'd0;
            tp_reg        <= 5'd0;
            fresh_reg     <= 1'b1;
            mstrtp_q1_reg <= 1'b0;
            mstrtp_q2_reg <= 1'b0;
            fs_reg        <= '0;
        end else begin
            state_reg     <= state_next;
            ph_reg        <= ph_next;
            tp_reg        <= tp_next;
            fresh_reg     <= 1'b0;
            mstrtp_q1_reg <= MSTRTP;
            mstrtp_q2_reg <= mstrtp_q1_reg;
            fs_reg        <= fs_reg + SCALER_W'(1);
        end
    end

    // Registered outputs decoded from the next state and position.
    always_ff @(posedge CLOCK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            t_reg       <= '0;
            ph_out_reg  <= 3'd0;
            rt_reg      <= 1'b0;
            wt_reg      <= 1'b0;
            ct_reg      <= 1'b0;
            mct_end_reg <= 1'b0;
            gojam_reg   <= 1'b1;
            stop_reg    <= 1'b0;
        end else begin
            t_reg       <= t_next;
            ph_out_reg  <= counting_next ? ph_next : 3'd0;
            rt_reg      <= counting_next && (ph_next == RT_SEL);
            wt_reg      <= counting_next && (ph_next == WT_SEL);
            ct_reg      <= counting_next && (ph_next == CT_SEL);
            mct_end_reg <= mct_end_next;
            gojam_reg   <= (state_next == S_JAM);
            stop_reg    <= (state_next == S_STOPPED);
        end
    end

`ifdef MCT_COUNT_EN
    logic [31:0] mctcnt_reg;

    // Completed-MCT counter; survives restarts, cleared only by reset.
    always_ff @(posedge CLOCK or negedge SIM_RST) begin
        if (!SIM_RST) mctcnt_reg <= 32'd0;
        else          mctcnt_reg <= mctcnt_reg + 32'(mct_end_next);
    end

    assign MCTCNT = mctcnt_reg;
`else
    assign MCTCNT = 32'd0;
`endif

    assign T       = t_reg;
    assign PH      = ph_out_reg;
    assign RT      = rt_reg;
    assign WT      = wt_reg;
    assign CT      = ct_reg;
    assign MCT_END = mct_end_reg;
    assign GOJAM   = gojam_reg;
    assign GOJAM_n = ~gojam_reg;
    assign STOP    = stop_reg;
    assign STOP_n  = ~stop_reg;
    assign FS      = fs_reg;

endmodule

// File: doc/mct_pulse_generator.md
Name: mct_pulse_generator

Overview:
Parametrised memory-cycle-time (MCT) pulse generator. It is the next generation of the fixed 12-pulse timer in the agc top level.
- Produces one-hot time pulses T01..Tn, each subdivided into phases.
- Produces per-phase read, write and clear strobes (RT, WT, CT).
- Drives the GOJAM restart sequence, standby, and monitor stop/single-MCT-step.
- Free-running scaler feeds downstream stage/branch and crosspoint logic.

Parameters:
NT, 12, time pulses per MCT (2..32)
NPH, 4, clock phases per time pulse (2..8)
RT_PH, 1, phase index at which RT asserts (< NPH)
WT_PH, 2, phase index at which WT asserts (< NPH)
CT_PH, 3, phase index at which CT asserts (< NPH)
SCALER_W, 16, scaler width in bits

Ports:
CLOCK  in  1  system clock, all state on rising edge
SIM_RST  in  1  asynchronous active-low reset
STRT1  in  1  restart request (level)
STRT2  in  1  restart request (level)
ALGA  in  1  alarm restart request (level)
SBY  in  1  standby request (level)
MSTP  in  1  monitor stop request (level)
MSTRTP  in  1  monitor step request; rising edge is significant
T  out  NT  one-hot time pulses, bit0 = T01
PH  out  3  current phase index
RT  out  1  read strobe
WT  out  1  write strobe
CT  out  1  clear strobe
MCT_END  out  1  high on last phase of last pulse
GOJAM  out  1  restart sequence active
GOJAM_n  out  1  inverse of GOJAM
STOP  out  1  held stopped by monitor
STOP_n  out  1  inverse of STOP
FS  out  SCALER_W  scaler count
MCTCNT  out  32  completed-MCT count (optional feature)

Behaviour:
- Clock and reset: one clock, CLOCK. SIM_RST is asynchronous and active-low. All outputs are registered.
- Reset values: T=0, PH=0, RT=WT=CT=0, MCT_END=0, GOJAM=1, GOJAM_n=0, STOP=0, STOP_n=1, FS=0, MCTCNT=0. State is JAM.
- States: JAM, RUN, STOPPED, STEP, STBY.
- Counters: phase counter ph (0..NPH-1) and pulse counter tp (0..NT-1).
- Counting in JAM, RUN and STEP:
  - ph increments every clock and wraps at NPH-1, which advances tp.
  - tp wraps at NT-1.
- Outputs in JAM, RUN and STEP:
  - T = 1<<tp and PH = ph.
  - RT/WT/CT are high when ph equals RT_PH/WT_PH/CT_PH respectively.
  - MCT_END is high when tp=NT-1 and ph=NPH-1.
- Edge numbering: edge 0 is the first rising edge after reset release. At edge k, ph = k mod NPH and tp = (k div NPH) mod NT. Defaults give MCT_END at edge 47 and T01 again at edge 48.
- JAM: GOJAM=1 for one complete MCT from T01 ph0. On MCT_END the next state is STOPPED if MSTP=1, otherwise RUN. GOJAM falls on the edge after MCT_END.
- RUN: on MCT_END, go to STOPPED if MSTP=1. MSTP is sampled only at MCT_END, so an MSTP rise mid-MCT lets the current MCT finish.
- STOPPED:
  - Outputs: T=0, strobes=0, MCT_END=0, STOP=1.
  - MSTRTP rising edge (registered edge detect): go to STEP, with T01 ph0 on the edge after detection. STOP falls with it.
  - MSTP=0: go to RUN starting at T01 ph0 on the next edge.
- STEP: runs exactly one MCT. At MCT_END, return to STOPPED if MSTP=1, else go to RUN. MSTRTP edges during STEP are ignored.
- STBY: T=0, strobes=0, GOJAM=0, STOP=0. On SBY falling, enter JAM at T01 ph0 on the next edge.
- Priority, evaluated every edge: (STRT1|STRT2|ALGA) > SBY > MSTP/MSTRTP.
- Restart:
  - Any restart input high aborts the current MCT in any state. The next edge gives JAM, T01 ph0, GOJAM=1.
  - While a restart input stays high, the counters hold at T01 ph0 with GOJAM=1. Counting resumes on the first edge after release.
- SBY in any non-restart state enters STBY on the next edge.
- Scaler: FS increments every clock in every state and wraps from 2^SCALER_W-1 to 0. It is cleared only by SIM_RST.
- Reset asserted mid-MCT: all outputs take their reset values immediately, asynchronously.

Optional Feature:
- Macro: MCT_COUNT_EN.
- Defined: MCTCNT increments on every edge where MCT_END=1 (any state) and wraps at 2^32. Restart does not clear it; only SIM_RST does.
- Undefined: MCTCNT is tied to 0 and no counter logic is built.

Test Plan:
- Reset then release, defaults, all inputs low:
  - T=0x001 with GOJAM=1 at edge 0; RT at edge 1; MCT_END at edge 47.
  - GOJAM=0 and T=0x001 at edge 48; T=0x800 on edges 44-47.
- RUN with MSTP raised at edge 60: MCT completes, MCT_END at edge 95, STOP=1 and T=0 from edge 96.
- STOPPED then one MSTRTP pulse: exactly one 48-clock MCT; STOP returns to 1 afterwards. A second MSTRTP pulse during STEP causes no extra MCT.
- STRT1 pulsed at edge 70 (mid-T06):
  - Edge 71: T=0x001, PH=0, GOJAM=1.
  - GOJAM clears 48 edges after the restart's first counting edge.
  - STRT1 held 5 clocks: T01 ph0 held for 5 edges.
- SBY and STRT2 high together: restart wins. With STRT2 low and SBY high: T=0. SBY falls: JAM sequence with GOJAM=1 for 48 clocks.
- SCALER_W=4: FS wraps 15 to 0 in all states. With MCT_COUNT_EN, MCTCNT=3 after 144 running clocks.
